div_ctrl: RTL and testbench

Execute-stage controller that issues DIV/DIVU to the iterative 32-bit divider and holds the pipeline until the result returns. It latches the operands and signedness, drives the divider's start/annul handshake, and raises the stall request. On completion it delivers remainder and quotient to the HI/LO register write port. It guarantees the divider is back in its free state before issuing the next operation, including after a flush.

---
 rtl/div_ctrl.sv | 115 +++++++++++
 tb/tb_div_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: execute-stage controller for the iterative 32-bit divider.
// Issues DIV/DIVU, holds the pipeline until the result returns, writes
// {remainder, quotient} to HI/LO, and makes sure the divider has returned
// to its free state before the next issue, including after a flush.
//
// Handshake (valid/ready): div_start is the request and stays high from the
// cycle after issue until the cycle div_ready (or a flush) is seen in BUSY.
// div_ready remains high until div_start drops. div_annul is a one-cycle
// cancel pulse that is only raised while a request is outstanding.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_div,
  input  logic        ex_divu,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  input  logic        flush,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        stallreq_div,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   drain_cnt_q;
  logic   req;
  logic   issue;

  assign req   = ex_valid & (ex_div | ex_divu) & ~flush;
  assign issue = (state_q == S_IDLE) & req;

  // State register, request line, drain counter and latched operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 1'b0;
      div_start   <= 1'b0;
      div_signed  <= 1'b0;
      div_opdata1 <= 32'd0;
      div_opdata2 <= 32'd0;
    end else begin
      state_q     <= state_d;
      // Counts the two DRAIN cycles; wraps back to 0 on the way out.
      drain_cnt_q <= (state_q == S_DRAIN) ? ~drain_cnt_q : 1'b0;
      // Request stays up exactly as long as we remain in BUSY.
      div_start   <= (state_d == S_BUSY);
      // Operands only move on an issue: the divider re-reads them in its
      // final sign-fix step.
      if (issue) begin
        div_signed  <= ex_div;
        div_opdata1 <= ex_op1;
        div_opdata2 <= ex_op2;
      end
    end
  end

  // Next-state logic; flush wins over div_ready in BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_BUSY;
      S_BUSY: begin
        if (flush)          state_d = S_DRAIN;
        else if (div_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (drain_cnt_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state and this cycle's inputs.
  always_comb begin
    stallreq_div = 1'b0;
    div_annul    = 1'b0;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    case (state_q)
      S_IDLE:  stallreq_div = req;
      S_BUSY: begin
        stallreq_div = ~div_ready | flush;
        div_annul    = flush;
        hi_we        = div_ready & ~flush;
        lo_we        = div_ready & ~flush;
      end
      // A new divide waiting here is held and issues from IDLE next cycle.
      S_DONE:  stallreq_div = req;
      S_DRAIN: stallreq_div = req;
      default: stallreq_div = 1'b0;
    endcase
  end

  assign hi_wdata  = div_result[63:32];
  assign lo_wdata  = div_result[31:0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl with a behavioural iterative-divider stand-in.
module tb_div_ctrl;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_div;
  logic        ex_divu;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        flush;
  logic [63:0] div_result;
  logic        div_ready;
  logic        div_start;
  logic        div_annul;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        stallreq_div;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_div       (ex_div),
    .ex_divu      (ex_divu),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .flush        (flush),
    .div_result   (div_result),
    .div_ready    (div_ready),
    .div_start    (div_start),
    .div_annul    (div_annul),
    .div_signed   (div_signed),
    .div_opdata1  (div_opdata1),
    .div_opdata2  (div_opdata2),
    .stallreq_div (stallreq_div),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .hi_wdata     (hi_wdata),
    .lo_wdata     (lo_wdata),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- divider stand-in ----------------
  // FREE -> DIV (33 iteration edges) -> END, or FREE -> ZERO -> END for a
  // zero divisor. END and ZERO only leave once start is low.
  localparam int M_FREE = 0;
  localparam int M_DIV  = 1;
  localparam int M_ZERO = 2;
  localparam int M_END  = 3;

  int          m_state;
  int          m_cnt;
  logic [63:0] m_res;

  function automatic logic [63:0] div_math(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = a; sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= M_FREE;
      m_cnt   <= 0;
      m_res   <= 64'd0;
    end else begin
      case (m_state)
        M_FREE: if (div_start && !div_annul) begin
          m_cnt   <= 0;
          m_state <= (div_opdata2 == 32'd0) ? M_ZERO : M_DIV;
        end
        M_ZERO: begin
          m_res   <= 64'd0;
          m_state <= M_END;
        end
        M_DIV: begin
          if (div_annul) m_state <= M_FREE;
          else if (m_cnt == 32) begin
            m_res   <= div_math(div_signed, div_opdata1, div_opdata2);
            m_state <= M_END;
          end else m_cnt <= m_cnt + 1;
        end
        default: if (!div_start) m_state <= M_FREE;
      endcase
    end
  end

  assign div_ready  = (m_state == M_END);
  assign div_result = m_res;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Clear EX inputs; call right after posedge+1.
  task automatic drive_none();
    ex_valid = 1'b0; ex_div = 1'b0; ex_divu = 1'b0;
    ex_op1 = 32'd0; ex_op2 = 32'd0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_none();
    end
  endtask

  // Present a divide in EX (called just after posedge+1 of its first EX
  // cycle) and hold it until the stall drops. Returns after the negedge of
  // the cycle in which the instruction advances.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_stall,
                        input logic [1:0] exp_state0);
    int stall_n, we_n, we_cyc;
    logic [31:0] hi_v, lo_v, op1_v, op2_v;
    logic done;
    stall_n = 0; we_n = 0; we_cyc = -1; done = 1'b0;
    hi_v = 32'hx; lo_v = 32'hx; op1_v = 32'hx; op2_v = 32'hx;
    ex_valid = 1'b1; ex_div = sgn; ex_divu = ~sgn;
    ex_op1 = a; ex_op2 = b; flush = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check({tag, "_state0"}, 64'(dbg_state), 64'(exp_state0));
        if (exp_state0 == ST_DONE) check({tag, "_done_start"}, 64'(div_start), 64'd0);
      end
      if (div_start && dbg_state == ST_BUSY && stall_n == exp_stall - 34)
        check({tag, "_signed"}, 64'(div_signed), 64'(sgn));
      if (hi_we || lo_we) begin
        we_n++;
        we_cyc = cyc;
        hi_v = hi_wdata; lo_v = lo_wdata;
        op1_v = div_opdata1; op2_v = div_opdata2;
        check({tag, "_we_pair"}, 64'({hi_we, lo_we}), 64'd3);
      end
      if (!stallreq_div) begin
        done = 1'b1;
        break;
      end
      stall_n++;
      @(posedge clk); #1;
    end
    if (!done) check({tag, "_timeout"}, 64'd1, 64'd0);
    check({tag, "_stall"}, 64'(stall_n), 64'(exp_stall));
    check({tag, "_we_count"}, 64'(we_n), 64'd1);
    check({tag, "_we_cycle"}, 64'(we_cyc), 64'(exp_stall));
    check({tag, "_hi"}, 64'(hi_v), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo_v), 64'(exp_lo));
    check({tag, "_opdata1"}, 64'(op1_v), 64'(a));
    check({tag, "_opdata2"}, 64'(op2_v), 64'(b));
  endtask

  // Snapshot of every DUT output against reset values (wdata follows result).
  task automatic check_reset_outs(input string tag);
    check({tag, "_start"},  64'(div_start), 64'd0);
    check({tag, "_annul"},  64'(div_annul), 64'd0);
    check({tag, "_signed"}, 64'(div_signed), 64'd0);
    check({tag, "_op1"},    64'(div_opdata1), 64'd0);
    check({tag, "_op2"},    64'(div_opdata2), 64'd0);
    check({tag, "_stall"},  64'(stallreq_div), 64'd0);
    check({tag, "_we"},     64'({hi_we, lo_we}), 64'd0);
    check({tag, "_state"},  64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int annul_n, we_n;
    total = 0; bad = 0;
    rst = 1'b0;
    drive_none();
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");
    @(negedge clk) rst = 1'b1;
    idle(2);

    // Unsigned divide
    @(posedge clk); #1;
    do_div("divu_max", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF,
           35, ST_IDLE);
    idle(3);

    // Signed, mixed signs
    @(posedge clk); #1;
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 35, ST_IDLE);
    idle(3);
    @(posedge clk); #1;
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, ST_IDLE);
    idle(3);

    // Divide by zero
    @(posedge clk); #1;
    do_div("div_zero", 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 3, ST_IDLE);
    idle(3);

    // Back-to-back: second DIVU enters EX in the DONE cycle
    @(posedge clk); #1;
    do_div("b2b_a", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 35, ST_IDLE);
    @(posedge clk); #1;
    do_div("b2b_b", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 36, ST_DONE);
    idle(3);

    // Flush in BUSY cycle T10, new DIVU 8/2 at T11
    annul_n = 0; we_n = 0;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_divu = 1'b1; ex_div = 1'b0; ex_op1 = 32'd50; ex_op2 = 32'd5;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      annul_n += int'(div_annul);
      we_n += int'(hi_we | lo_we);
      @(posedge clk); #1;
    end
    check("flush_pre_annul", 64'(annul_n), 64'd0);
    drive_none();
    flush = 1'b1;
    @(negedge clk);
    check("flush_t10_state", 64'(dbg_state), 64'(ST_BUSY));
    check("flush_t10_annul", 64'(div_annul), 64'd1);
    check("flush_t10_stall", 64'(stallreq_div), 64'd1);
    we_n += int'(hi_we | lo_we);
    check("flush_no_write", 64'(we_n), 64'd0);
    @(posedge clk); #1;
    do_div("flush_new", 1'b0, 32'd8, 32'd2, 32'd0, 32'd4, 37, ST_DRAIN);
    idle(3);

    // Async reset in T20 of a divide
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_divu = 1'b1; ex_div = 1'b0; ex_op1 = 32'd1000; ex_op2 = 32'd3;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("rst_pre_busy", 64'(dbg_state), 64'(ST_BUSY));
    drive_none();
    rst = 1'b0;
    #1 check_reset_outs("rst_mid");
    @(negedge clk) rst = 1'b1;
    idle(2);
    @(posedge clk); #1;
    do_div("after_rst", 1'b0, 32'd6, 32'd4, 32'd2, 32'd1, 35, ST_IDLE);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
